dma_ob_cmd_decoder: RTL and testbench
=====================================

// Module: dma_ob_cmd_decoder
// PURPOSE
//  Consumes the software-to-firmware outbound DMA stream (64-bit AXIS, DMA0) and executes each beat as a
//  register command on the internal strobe/ack bus (wstr/rstr/wack/rack, 18-bit word address, 32-bit data).
//  Every command beat returns exactly one 64-bit response beat on an AXIS master, so software has an
//  in-band register path that parallels AXI-Lite. Sits in the DPM top between dmaObMaster/dmaObSlave and a
//  response stream that is merged onto the inbound DMA path.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles to wait for wack/rack before aborting the command (1..65535)
// PORTS
//  dmaClk      in   1   sole clock
//  dmaRst      in   1   reset, asynchronous, active-high
//  ob_tvalid   in   1   outbound command beat valid
//  ob_tdata    in   64  [63:62] op (00 nop, 01 write, 10 read, 11 illegal), [49:32] addr, [31:0] data
//  ob_tkeep    in   8   byte keep; only 8'hFF is legal
//  ob_tlast    in   1   last beat of command frame
//  ob_tready   out  1   decoder accepts a beat
//  cmd_wstr    out  1   one-cycle write strobe
//  cmd_rstr    out  1   one-cycle read strobe
//  cmd_addr    out  18  word address, held from strobe until response issued
//  cmd_din     out  32  write data, held like cmd_addr
//  cmd_wack    in   1   write acknowledge
//  cmd_rack    in   1   read acknowledge; cmd_dout valid in the same cycle
//  cmd_dout    in   32  read data
//  rsp_tvalid  out  1   response beat valid
//  rsp_tdata   out  64  [63:62] op echo, [61] timeout, [60] format error, [49:32] addr, [31:0] data
//  rsp_tlast   out  1   copy of ob_tlast of the originating beat
//  rsp_tready  in   1   response sink ready
//  err_count   out  16  saturating count of timeouts plus format errors
//  busy        out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state IDLE; ob_tready=0 during reset, 1 the first cycle after; wstr/rstr/rsp_tvalid/
//   rsp_tlast=0; cmd_addr, cmd_din, rsp_tdata, err_count=0. Any in-flight command is lost with no response.
//  FSM: IDLE -> EXEC -> WAIT_ACK -> RESP -> IDLE. Nop and format-error beats take IDLE -> RESP directly.
//  IDLE: ob_tready=1 (registered). On tvalid&tready, latch beat, drop tready, then:
//   - op 01/10 with tkeep=FF -> EXEC
//   - op 00 -> RESP, data 0, flags 0
//   - op 11 or tkeep!=FF -> RESP, bit60=1, data 0, no strobe, err_count+1
//  EXEC: exactly one cycle, asserts cmd_wstr (op 01) or cmd_rstr (op 10) -> WAIT_ACK, timer cleared.
//  WAIT_ACK: acks are sampled from the cycle after the strobe; an ack in the strobe cycle is ignored.
//   - write: cmd_wack -> RESP, data = written data
//   - read: cmd_rack -> RESP, data = cmd_dout sampled that cycle
//   - wrong-type ack is ignored.
//   - timer reaches TIMEOUT_CYC with no ack -> RESP, bit61=1, data 32'hDEADBEEF, err_count+1
//  RESP: rsp_tvalid=1 with rsp_tdata/rsp_tlast stable until rsp_tready. The handshake cycle -> IDLE,
//   and tready=1 on the next cycle.
//  Latency: accept at cycle N, strobe at N+1, ack at N+2 at the earliest, rsp_tvalid at N+3.
//  Throughput: one command is in flight at a time, with no pipelining.
//  err_count saturates at 16'hFFFF. A timeout and a format error never coincide; each event adds 1.
//  Framing: beats are processed independently; tlast only propagates and never resets state.
//  Bits [61:50] of ob_tdata are ignored. The same bits in rsp_tdata are 0 except flags 61/60.
// TESTING
//  1. Write beat {01,addr 0x00123,data 0xCAFEF00D}, tlast=1, wack 2 cycles after strobe -> one-cycle
//     wstr with addr 0x00123, rsp_tdata=0x4000_0123_CAFE_F00D, rsp_tlast=1.
//  2. Read beat addr 0x3FFFF, rack+dout 0x12345678 next cycle -> rsp_tvalid at N+3,
//     rsp_tdata=0x8003_FFFF_1234_5678.
//  3. Read, no rack, TIMEOUT_CYC=255 -> after 255 wait cycles rsp_tdata=0xA00x_xxxx_DEAD_BEEF, err_count=1.
//  4. tkeep=0x0F beat, then op 11 beat -> no strobes, two responses with bit60 set, err_count=2.
//  5. rsp_tready held low 10 cycles -> rsp_tdata stable, ob_tready=0 throughout, next beat accepted
//     the cycle after the handshake.
//  6. Assert dmaRst while in WAIT_ACK -> outputs clear asynchronously, no response emitted, and the
//     next command completes normally.

Source files
------------

// File: rtl/dma_ob_cmd_decoder.sv
`timescale 1ns/1ps
// Executes outbound DMA beats as strobe/ack register commands and returns one response beat per command.
// Latency: accept at N, strobe at N+1, earliest ack at N+2, response valid at N+3; nop/format error respond at N+1.
// Backpressure: one command in flight; ob_tready stays low from accept until the response handshake completes.
module dma_ob_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        dmaClk,
    input  logic        dmaRst,
    input  logic        ob_tvalid,
    input  logic [63:0] ob_tdata,
    input  logic [7:0]  ob_tkeep,
    input  logic        ob_tlast,
    output logic        ob_tready,
    output logic        cmd_wstr,
    output logic        cmd_rstr,
    output logic [17:0] cmd_addr,
    output logic [31:0] cmd_din,
    input  logic        cmd_wack,
    input  logic        cmd_rack,
    input  logic [31:0] cmd_dout,
    output logic        rsp_tvalid,
    output logic [63:0] rsp_tdata,
    output logic        rsp_tlast,
    input  logic        rsp_tready,
    output logic [15:0] err_count,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT_ACK, RESP} state_t;

    localparam logic [1:0]  OP_NOP   = 2'b00;
    localparam logic [1:0]  OP_WR    = 2'b01;
    localparam logic [1:0]  OP_RD    = 2'b10;
    localparam logic [1:0]  OP_ILL   = 2'b11;
    // Timer counts completed wait cycles, so the last legal value is one short of the limit.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [1:0]  op_q;
    logic [15:0] timer;

    logic [1:0]  beat_op;
    logic [17:0] beat_addr;
    logic [31:0] beat_data;
    logic        beat_fmt_err;
    logic [15:0] err_count_inc;
    logic        unused_bits;

    assign beat_op      = ob_tdata[63:62];
    assign beat_addr    = ob_tdata[49:32];
    assign beat_data    = ob_tdata[31:0];
    assign beat_fmt_err = (ob_tkeep != 8'hFF) || (beat_op == OP_ILL);
    // Reserved command bits carry no meaning and are dropped.
    assign unused_bits  = ^ob_tdata[61:50];
    // Saturating increment: adds one unless already at all-ones.
    assign err_count_inc = err_count + {15'd0, ~&err_count};
    assign busy          = (state != IDLE);

    function automatic logic [63:0] rsp_word(input logic [1:0]  op,
                                             input logic        tmo,
                                             input logic        fmt,
                                             input logic [17:0] addr,
                                             input logic [31:0] data);
        return {op, tmo, fmt, 10'h000, addr, data};
    endfunction

    // Command FSM: accept beat, strobe, wait for ack or timeout, hold response until taken.
    always_ff @(posedge dmaClk or posedge dmaRst) begin
        if (dmaRst) begin
            state      <= IDLE;
            ob_tready  <= 1'b0;
            cmd_wstr   <= 1'b0;
            cmd_rstr   <= 1'b0;
            cmd_addr   <= '0;
            cmd_din    <= '0;
            op_q       <= OP_NOP;
            timer      <= '0;
            rsp_tvalid <= 1'b0;
            rsp_tdata  <= '0;
            rsp_tlast  <= 1'b0;
            err_count  <= '0;
        end else begin
            cmd_wstr <= 1'b0;
            cmd_rstr <= 1'b0;
            case (state)
                IDLE: begin
                    ob_tready <= 1'b1;
                    if (ob_tvalid && ob_tready) begin
                        ob_tready <= 1'b0;
                        op_q      <= beat_op;
                        rsp_tlast <= ob_tlast;
                        if (beat_fmt_err) begin
                            state      <= RESP;
                            rsp_tvalid <= 1'b1;
                            rsp_tdata  <= rsp_word(beat_op, 1'b0, 1'b1, beat_addr, 32'h0);
                            err_count  <= err_count_inc;
                        end else if (beat_op == OP_NOP) begin
                            state      <= RESP;
                            rsp_tvalid <= 1'b1;
                            rsp_tdata  <= rsp_word(beat_op, 1'b0, 1'b0, beat_addr, 32'h0);
                        end else begin
                            state    <= EXEC;
                            cmd_addr <= beat_addr;
                            cmd_din  <= beat_data;
                            cmd_wstr <= (beat_op == OP_WR);
                            cmd_rstr <= (beat_op == OP_RD);
                        end
                    end
                end
                EXEC: begin
                    // Strobe is visible this cycle; acks are only honoured from the next one.
                    state <= WAIT_ACK;
                    timer <= '0;
                end
                WAIT_ACK: begin
                    if ((op_q == OP_WR) && cmd_wack) begin
                        state      <= RESP;
                        rsp_tvalid <= 1'b1;
                        rsp_tdata  <= rsp_word(op_q, 1'b0, 1'b0, cmd_addr, cmd_din);
                    end else if ((op_q == OP_RD) && cmd_rack) begin
                        state      <= RESP;
                        rsp_tvalid <= 1'b1;
                        rsp_tdata  <= rsp_word(op_q, 1'b0, 1'b0, cmd_addr, cmd_dout);
                    end else if (timer == TMO_LAST) begin
                        state      <= RESP;
                        rsp_tvalid <= 1'b1;
                        rsp_tdata  <= rsp_word(op_q, 1'b1, 1'b0, cmd_addr, 32'hDEADBEEF);
                        err_count  <= err_count_inc;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_tready) begin
                        rsp_tvalid <= 1'b0;
                        ob_tready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_ob_cmd_decoder.sv
`timescale 1ns/1ps
// Directed bench for dma_ob_cmd_decoder: hand-computed response words, latency and hold behaviour.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// Response sink is ready by default; the hold test drops it explicitly.
module tb_dma_ob_cmd_decoder;

    logic        dmaClk = 1'b0;
    logic        dmaRst = 1'b1;
    logic        ob_tvalid = 1'b0;
    logic [63:0] ob_tdata = '0;
    logic [7:0]  ob_tkeep = 8'hFF;
    logic        ob_tlast = 1'b0;
    logic        ob_tready;
    logic        cmd_wstr;
    logic        cmd_rstr;
    logic [17:0] cmd_addr;
    logic [31:0] cmd_din;
    logic        cmd_wack = 1'b0;
    logic        cmd_rack = 1'b0;
    logic [31:0] cmd_dout = '0;
    logic        rsp_tvalid;
    logic [63:0] rsp_tdata;
    logic        rsp_tlast;
    logic        rsp_tready = 1'b1;
    logic [15:0] err_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int wstr_cnt = 0;
    int rstr_cnt = 0;
    int rsp_cnt  = 0;
    int snap_w, snap_r, snap_rsp;

    dma_ob_cmd_decoder #(.TIMEOUT_CYC(255)) dut (
        .dmaClk(dmaClk), .dmaRst(dmaRst),
        .ob_tvalid(ob_tvalid), .ob_tdata(ob_tdata), .ob_tkeep(ob_tkeep), .ob_tlast(ob_tlast),
        .ob_tready(ob_tready),
        .cmd_wstr(cmd_wstr), .cmd_rstr(cmd_rstr), .cmd_addr(cmd_addr), .cmd_din(cmd_din),
        .cmd_wack(cmd_wack), .cmd_rack(cmd_rack), .cmd_dout(cmd_dout),
        .rsp_tvalid(rsp_tvalid), .rsp_tdata(rsp_tdata), .rsp_tlast(rsp_tlast), .rsp_tready(rsp_tready),
        .err_count(err_count), .busy(busy)
    );

    always #5 dmaClk = ~dmaClk;

    // Count strobes and completed response handshakes.
    always @(posedge dmaClk) begin
        if (cmd_wstr) wstr_cnt <= wstr_cnt + 1;
        if (cmd_rstr) rstr_cnt <= rstr_cnt + 1;
        if (rsp_tvalid && rsp_tready) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat from a falling edge, wait (bounded) for ready, return on the falling edge after accept.
    task automatic accept_beat(input logic [1:0] op, input logic [17:0] addr, input logic [31:0] data,
                               input logic [7:0] keep, input logic last);
        int k = 0;
        ob_tdata  = {op, 12'hFFF, addr, data};
        ob_tkeep  = keep;
        ob_tlast  = last;
        ob_tvalid = 1'b1;
        while (!ob_tready && k < 20) begin
            @(negedge dmaClk);
            k++;
        end
        check("accept_wait", 64'(k >= 20), 64'd0);
        @(posedge dmaClk);
        @(negedge dmaClk);
        ob_tvalid = 1'b0;
    endtask

    // Wait (bounded) for a response, check it, and return after the handshake edge.
    task automatic expect_rsp(input string tag, input logic [63:0] exp, input logic exp_last);
        int k = 0;
        while (!rsp_tvalid && k < 300) begin
            @(negedge dmaClk);
            k++;
        end
        check({tag, "_wait"}, 64'(k >= 300), 64'd0);
        check({tag, "_data"}, rsp_tdata, exp);
        check({tag, "_last"}, 64'(rsp_tlast), 64'(exp_last));
        @(negedge dmaClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge dmaClk);
        check("rst_tready", 64'(ob_tready), 64'd0);
        check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        dmaRst = 1'b0;
        @(negedge dmaClk);
        check("post_rst_tready", 64'(ob_tready), 64'd1);

        // Write with a wrong-type ack and a strobe-cycle ack that must both be ignored.
        accept_beat(2'b01, 18'h00123, 32'hCAFEF00D, 8'hFF, 1'b1);
        check("t1_wstr", 64'(cmd_wstr), 64'd1);
        check("t1_addr", 64'(cmd_addr), 64'h123);
        check("t1_din", 64'(cmd_din), 64'hCAFEF00D);
        check("t1_tready_low", 64'(ob_tready), 64'd0);
        cmd_wack = 1'b1;
        @(negedge dmaClk);
        check("t1_wstr_one_cycle", 64'(cmd_wstr), 64'd0);
        cmd_wack = 1'b0;
        cmd_rack = 1'b1;
        @(negedge dmaClk);
        check("t1_no_early_rsp", 64'(rsp_tvalid), 64'd0);
        cmd_rack = 1'b0;
        cmd_wack = 1'b1;
        @(negedge dmaClk);
        cmd_wack = 1'b0;
        check("t1_rsp_valid", 64'(rsp_tvalid), 64'd1);
        expect_rsp("t1", 64'h4000_0123_CAFE_F00D, 1'b1);
        check("t1_wstr_count", 64'(wstr_cnt), 64'd1);
        check("t1_tready_back", 64'(ob_tready), 64'd1);

        // Read with ack on the cycle after the strobe: response valid three cycles after accept.
        accept_beat(2'b10, 18'h3FFFF, 32'h0, 8'hFF, 1'b0);
        check("t2_rstr", 64'(cmd_rstr), 64'd1);
        check("t2_addr", 64'(cmd_addr), 64'h3FFFF);
        @(negedge dmaClk);
        cmd_rack = 1'b1;
        cmd_dout = 32'h12345678;
        @(negedge dmaClk);
        cmd_rack = 1'b0;
        cmd_dout = 32'h0;
        check("t2_latency", 64'(rsp_tvalid), 64'd1);
        expect_rsp("t2", 64'h8003_FFFF_1234_5678, 1'b0);
        check("t2_rstr_count", 64'(rstr_cnt), 64'd1);

        // Read that never gets an ack: timeout after 255 wait cycles.
        accept_beat(2'b10, 18'h00055, 32'h0, 8'hFF, 1'b1);
        check("t3_rstr", 64'(cmd_rstr), 64'd1);
        repeat (255) @(negedge dmaClk);
        check("t3_not_yet", 64'(rsp_tvalid), 64'd0);
        @(negedge dmaClk);
        check("t3_timeout_valid", 64'(rsp_tvalid), 64'd1);
        expect_rsp("t3", 64'hA000_0055_DEAD_BEEF, 1'b1);
        check("t3_err_count", 64'(err_count), 64'd1);

        // Reset in the middle of WAIT_ACK, then a normal read.
        accept_beat(2'b01, 18'h00099, 32'h00000077, 8'hFF, 1'b0);
        @(negedge dmaClk);
        check("t6_busy_before", 64'(busy), 64'd1);
        snap_rsp = rsp_cnt;
        dmaRst = 1'b1;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_tready", 64'(ob_tready), 64'd0);
        check("t6_addr", 64'(cmd_addr), 64'd0);
        check("t6_din", 64'(cmd_din), 64'd0);
        check("t6_err_count", 64'(err_count), 64'd0);
        check("t6_rsp_tdata", rsp_tdata, 64'd0);
        @(negedge dmaClk);
        @(negedge dmaClk);
        dmaRst = 1'b0;
        @(negedge dmaClk);
        check("t6_tready_after", 64'(ob_tready), 64'd1);
        check("t6_no_rsp", 64'(rsp_cnt - snap_rsp), 64'd0);
        accept_beat(2'b10, 18'h00ABC, 32'h0, 8'hFF, 1'b1);
        @(negedge dmaClk);
        cmd_rack = 1'b1;
        cmd_dout = 32'h0BADF00D;
        @(negedge dmaClk);
        cmd_rack = 1'b0;
        cmd_dout = 32'h0;
        expect_rsp("t6", 64'h8000_0ABC_0BAD_F00D, 1'b1);

        // Format errors: bad keep, then illegal op; neither strobes.
        snap_w = wstr_cnt;
        snap_r = rstr_cnt;
        accept_beat(2'b01, 18'h00010, 32'h00000011, 8'h0F, 1'b1);
        check("t4_keep_valid", 64'(rsp_tvalid), 64'd1);
        expect_rsp("t4_keep", 64'h5000_0010_0000_0000, 1'b1);
        accept_beat(2'b11, 18'h00020, 32'h00000022, 8'hFF, 1'b0);
        expect_rsp("t4_ill", 64'hD000_0020_0000_0000, 1'b0);
        check("t4_err_count", 64'(err_count), 64'd2);
        check("t4_no_strobes", 64'((wstr_cnt - snap_w) + (rstr_cnt - snap_r)), 64'd0);

        // Response held under backpressure, next beat accepted right after the handshake.
        rsp_tready = 1'b0;
        accept_beat(2'b00, 18'h00007, 32'h0000FFFF, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_data", rsp_tdata, 64'h0000_0007_0000_0000);
            check("t5_hold_tready", 64'(ob_tready), 64'd0);
            @(negedge dmaClk);
        end
        snap_rsp = rsp_cnt;
        rsp_tready = 1'b1;
        ob_tdata  = {2'b01, 12'h000, 18'h0002A, 32'h00000005};
        ob_tkeep  = 8'hFF;
        ob_tlast  = 1'b0;
        ob_tvalid = 1'b1;
        @(negedge dmaClk);
        check("t5_rsp_taken", 64'(rsp_cnt - snap_rsp), 64'd1);
        check("t5_tready_next", 64'(ob_tready), 64'd1);
        check("t5_no_wstr_yet", 64'(cmd_wstr), 64'd0);
        @(negedge dmaClk);
        ob_tvalid = 1'b0;
        check("t5_wstr", 64'(cmd_wstr), 64'd1);
        check("t5_addr", 64'(cmd_addr), 64'h2A);
        @(negedge dmaClk);
        cmd_wack = 1'b1;
        @(negedge dmaClk);
        cmd_wack = 1'b0;
        expect_rsp("t5", 64'h4000_002A_0000_0005, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
